sram_seq_master: RTL

- Command-driven initiator for the SRAM controller's iADDR/iCE_N/iOE_N/iWE_N/iUB_N/iLB_N/iDATA/oDATA interface.
- Turns a valid/ready command stream of single 16-bit reads and writes into correctly sequenced strobe cycles.
- Captures read data and returns it on a valid/ready response channel.
- Sits between internal traffic sources (test engines, frame fillers) and the SRAM controller.

---
 rtl/sram_seq_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sram_seq_master.sv
// sram_seq_master: command-driven initiator for an async SRAM controller.
// Each accepted command runs as IDLE -> SETUP -> ACCESS x(WAIT_CYCLES+1) -> HOLD.
// All strobe and data outputs are registered.
// Read data is returned on a one-entry valid/ready response channel.
// Optional macro SRAM_SEQ_STATS_EN adds saturating write/read counters.
module sram_seq_master #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iCMD_VALID,
  output logic              oCMD_READY,
  input  logic              iCMD_WR,
  input  logic [ADDR_W-1:0] iCMD_ADDR,
  input  logic [DATA_W-1:0] iCMD_WDATA,
  input  logic [1:0]        iCMD_BE,
  output logic [ADDR_W-1:0] oADDR,
  output logic [DATA_W-1:0] oDATA,
  input  logic [DATA_W-1:0] iDATA,
  output logic              oCE_N,
  output logic              oOE_N,
  output logic              oWE_N,
  output logic              oUB_N,
  output logic              oLB_N,
  output logic              oRD_VALID,
  input  logic              iRD_READY,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic [15:0]       oWR_CNT,
  output logic [15:0]       oRD_CNT
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t            r_state, w_next;
  logic              r_wr;
  logic [1:0]        r_be;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;
  logic              w_cmd_ready, w_accept, w_rd_hs;

  // Ready depends on registers only; a pending read response blocks new commands.
  assign w_cmd_ready = (r_state == IDLE) & ~r_rd_valid;
  assign w_accept    = iCMD_VALID & w_cmd_ready;
  assign w_rd_hs     = r_rd_valid & iRD_READY;

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (r_cnt == 4'd0) w_next = HOLD;
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered strobes, address/data, wait counter and read capture
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wr       <= 1'b0;
      r_be       <= 2'b00;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_ub_n     <= 1'b1;
      r_lb_n     <= 1'b1;
    end else begin
      if (w_rd_hs) r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_wr   <= iCMD_WR;
          r_be   <= iCMD_BE;
          r_addr <= iCMD_ADDR;
          r_ce_n <= 1'b0;
          if (iCMD_WR) begin
            r_data <= iCMD_WDATA;
            r_ub_n <= ~iCMD_BE[1];
            r_lb_n <= ~iCMD_BE[0];
          end else begin
            r_oe_n <= 1'b0;
            r_ub_n <= 1'b0;
            r_lb_n <= 1'b0;
          end
        end
        SETUP: begin
          r_cnt <= LP_WAIT;
          // BE=00 is a timing-only no-op: WE never asserts
          if (r_wr) r_we_n <= ~(|r_be);
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_we_n <= 1'b1;
            r_oe_n <= 1'b1;
            if (!r_wr) begin
              r_rd_data  <= iDATA;
              r_rd_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          r_ce_n <= 1'b1;
          r_ub_n <= 1'b1;
          r_lb_n <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_SEQ_STATS_EN
  logic [15:0] r_wr_cnt, r_rd_cnt;

  // Saturating completion counters
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wr_cnt <= 16'h0000;
      r_rd_cnt <= 16'h0000;
    end else begin
      if (r_state == HOLD && r_wr && (|r_be) && r_wr_cnt != 16'hFFFF)
        r_wr_cnt <= r_wr_cnt + 16'h0001;
      if (w_rd_hs && r_rd_cnt != 16'hFFFF)
        r_rd_cnt <= r_rd_cnt + 16'h0001;
    end
  end

  assign oWR_CNT = r_wr_cnt;
  assign oRD_CNT = r_rd_cnt;
`else
  assign oWR_CNT = 16'h0000;
  assign oRD_CNT = 16'h0000;
`endif

  assign oCMD_READY = w_cmd_ready;
  assign oADDR      = r_addr;
  assign oDATA      = r_data;
  assign oCE_N      = r_ce_n;
  assign oOE_N      = r_oe_n;
  assign oWE_N      = r_we_n;
  assign oUB_N      = r_ub_n;
  assign oLB_N      = r_lb_n;
  assign oRD_VALID  = r_rd_valid;
  assign oRD_DATA   = r_rd_data;

endmodule
